// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared state encoding, default timing constants and a small
//                helper for the four-channel frame scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    // Default serializer cycles per frame: sync byte + 16 data bytes + tail
    localparam int c_SER_CYCLES_DEF = 35;

    // Default COLLECT cycles before a partial frame is forced out
    localparam int c_TIMEOUT_DEF = 1023;

    localparam int c_NUM_CHAN = 4;
    localparam int c_WORD_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_LAUNCH  = 2'd2,
        S_BUSY    = 2'd3
    } state_t;

    // A channel that did not deliver a sample contributes an all-zero word
    function automatic logic [c_WORD_W-1:0] frame_word(input logic flag,
                                                       input logic [c_WORD_W-1:0] data);
        return flag ? data : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : chan_capture
//  Description : One channel's capture register, pending flag and overrun
//                detector. A strobe while the flag is still pending (and not
//                being consumed by a launch on the same edge) is an overrun;
//                the new sample overwrites the old one.
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_capture
    import frame_pkg::*;
(
    input  logic                CLK,
    input  logic                nReset,
    input  logic                vld,
    input  logic [c_WORD_W-1:0] din,
    input  logic                clr,
    output logic [c_WORD_W-1:0] data,
    output logic                flag,
    output logic                ovr
);

    // Capture sample, track pending flag (set wins over clear), flag overruns
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            data <= '0;
            flag <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (vld) begin
                data <= din;
            end
            flag <= vld | (flag & ~clr);
            ovr  <= vld & flag & ~clr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scheduler
//  Description : Collects one 32-bit word from each of four channels and
//                launches a frame to a byte serializer when all channels have
//                delivered or a collection timeout expires, gated by the
//                downstream FIFO full indication (nTXE). Capture continues
//                while a frame is being serialized.
//                Optional feature macro: FRAME_OVR_COUNT_EN adds a 16-bit
//                saturating overrun counter output (OvrCnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler
    import frame_pkg::*;
#(
    parameter int SER_CYCLES = c_SER_CYCLES_DEF,
    parameter int TIMEOUT    = c_TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        nReset,
    input  logic [3:0]  vld,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic [31:0] inC,
    input  logic [31:0] inD,
    input  logic        nTXE,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] C,
    output logic [31:0] D,
    output logic        nClkEn,
    output logic        Busy,
    output logic [3:0]  Miss,
`ifdef FRAME_OVR_COUNT_EN
    output logic [15:0] OvrCnt,
`endif
    output logic        Ovr
);

    // One counter serves as the COLLECT timer and the BUSY cycle counter
    localparam int c_CNT_MAX = (TIMEOUT > SER_CYCLES) ? TIMEOUT : SER_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_TMO      = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_SER_LAST = c_CNT_W'(SER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [c_WORD_W-1:0]  w_din  [c_NUM_CHAN];
    logic [c_WORD_W-1:0]  w_data [c_NUM_CHAN];
    logic [c_NUM_CHAN-1:0] w_flag;
    logic [c_NUM_CHAN-1:0] w_ovr;
    logic                 w_launch;

    assign w_din[0] = inA;
    assign w_din[1] = inB;
    assign w_din[2] = inC;
    assign w_din[3] = inD;

    for (genvar i = 0; i < c_NUM_CHAN; i++) begin : g_chan
        chan_capture u_chan (
            .CLK    (CLK),
            .nReset (nReset),
            .vld    (vld[i]),
            .din    (w_din[i]),
            .clr    (w_launch),
            .data   (w_data[i]),
            .flag   (w_flag[i]),
            .ovr    (w_ovr[i])
        );
    end

    // Launch decision: complete set or expired timer, only when FIFO has room
    assign w_launch = (r_state == S_COLLECT) && !nTXE &&
                      ((&w_flag) || (r_cnt == c_TMO));

    // Overrun pulses from all channels merge into one strobe
    assign Ovr = |w_ovr;

    // Frame sequencing FSM with registered frame words and status outputs
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            A       <= '0;
            B       <= '0;
            C       <= '0;
            D       <= '0;
            Miss    <= '0;
            nClkEn  <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            nClkEn <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|vld) begin
                        r_state <= S_COLLECT;
                        r_cnt   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_launch) begin
                        r_state <= S_LAUNCH;
                        nClkEn  <= 1'b1;
                        Busy    <= 1'b1;
                        A       <= frame_word(w_flag[0], w_data[0]);
                        B       <= frame_word(w_flag[1], w_data[1]);
                        C       <= frame_word(w_flag[2], w_data[2]);
                        D       <= frame_word(w_flag[3], w_data[3]);
                        Miss    <= ~w_flag;
                    end else if (!nTXE && (r_cnt != c_TMO)) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_BUSY;
                    r_cnt   <= '0;
                end
                S_BUSY: begin
                    if (r_cnt == c_SER_LAST) begin
                        Busy  <= 1'b0;
                        r_cnt <= '0;
                        // A strobe on this edge also leaves a pending flag
                        if ((|w_flag) || (|vld)) begin
                            r_state <= S_COLLECT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_OVR_COUNT_EN
    // Saturating count of overrun pulses
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            OvrCnt <= '0;
        end else if (Ovr && (OvrCnt != 16'hFFFF)) begin
            OvrCnt <= OvrCnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scheduler
//  Description : Directed self-checking bench for frame_scheduler using the
//                default SER_CYCLES (35) and TIMEOUT (1023).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    logic        CLK;
    logic        nReset;
    logic [3:0]  vld;
    logic [31:0] inA, inB, inC, inD;
    logic        nTXE;
    logic [31:0] A, B, C, D;
    logic        nClkEn;
    logic        Busy;
    logic [3:0]  Miss;
    logic        Ovr;
`ifdef FRAME_OVR_COUNT_EN
    logic [15:0] OvrCnt;
`endif

    int n_chk;
    int n_fail;

    frame_scheduler u_dut (
        .CLK    (CLK),
        .nReset (nReset),
        .vld    (vld),
        .inA    (inA),
        .inB    (inB),
        .inC    (inC),
        .inD    (inD),
        .nTXE   (nTXE),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .nClkEn (nClkEn),
        .Busy   (Busy),
        .Miss   (Miss),
`ifdef FRAME_OVR_COUNT_EN
        .OvrCnt (OvrCnt),
`endif
        .Ovr    (Ovr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Run until Busy drops, bounded
    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        while (Busy && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        n_chk  = 0;
        n_fail = 0;
        nReset = 1'b0;
        vld    = 4'b0000;
        inA    = '0;
        inB    = '0;
        inC    = '0;
        inD    = '0;
        nTXE   = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        check_eq("rst_A", A, 32'd0);
        check_eq("rst_D", D, 32'd0);
        check_eq("rst_Miss", {28'd0, Miss}, 32'd0);
        check_eq("rst_nClkEn", {31'd0, nClkEn}, 32'd0);
        check_eq("rst_Busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_Ovr", {31'd0, Ovr}, 32'd0);
        nReset = 1'b1;
        tick();

        // ---------------- full frame, channels arrive one per cycle
        inA = 32'h11223344; inB = 32'hB1B2B3B4; inC = 32'hC1C2C3C4; inD = 32'hD1D2D3D4;
        vld = 4'b0001; tick();
        vld = 4'b0010; tick();
        vld = 4'b0100; tick();
        vld = 4'b1000; tick();
        vld = 4'b0000;
        check_eq("full_wait_nClkEn", {31'd0, nClkEn}, 32'd0);
        tick();
        check_eq("full_nClkEn", {31'd0, nClkEn}, 32'd1);
        check_eq("full_A", A, 32'h11223344);
        check_eq("full_B", B, 32'hB1B2B3B4);
        check_eq("full_D", D, 32'hD1D2D3D4);
        check_eq("full_Miss", {28'd0, Miss}, 32'd0);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            tick();
            if (n == 1) check_eq("full_nClkEn_pulse", {31'd0, nClkEn}, 32'd0);
        end
        check_eq("full_busy_len", n, 32'd36);
        check_eq("full_A_hold", A, 32'h11223344);
        tick();
        check_eq("full_idle_busy", {31'd0, Busy}, 32'd0);

        // ---------------- partial frame forced by timeout
        inA = 32'hA0000001; inC = 32'hC0000003;
        vld = 4'b0001; tick();
        vld = 4'b0100;
        n = 0;
        seen = 0;
        while (seen == 0 && n < 1100) begin
            tick();
            vld = 4'b0000;
            n++;
            if (nClkEn) seen = 1;
        end
        check_eq("tmo_latency", n, 32'd1024);
        check_eq("tmo_A", A, 32'hA0000001);
        check_eq("tmo_B", B, 32'd0);
        check_eq("tmo_C", C, 32'hC0000003);
        check_eq("tmo_D", D, 32'd0);
        check_eq("tmo_Miss", {28'd0, Miss}, 32'h0000000A);
        wait_not_busy("tmo_busy_end");

        // ---------------- FIFO full holds a complete frame
        nTXE = 1'b1;
        inA = 32'h0A0A0A0A; inB = 32'h0B0B0B0B; inC = 32'h0C0C0C0C; inD = 32'h0D0D0D0D;
        vld = 4'b1111; tick();
        vld = 4'b0000;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (nClkEn) seen++;
        end
        check_eq("txe_hold_none", seen, 32'd0);
        nTXE = 1'b0;
        tick();
        check_eq("txe_release_nClkEn", {31'd0, nClkEn}, 32'd1);
        check_eq("txe_A", A, 32'h0A0A0A0A);
        check_eq("txe_Miss", {28'd0, Miss}, 32'd0);
        nTXE = 1'b1;
        tick();
        check_eq("txe_busy_ignores_full", {31'd0, Busy}, 32'd1);
        nTXE = 1'b0;
        wait_not_busy("txe_busy_end");

        // ---------------- overrun on channel B
        inB = 32'h22220001;
        vld = 4'b0010; tick();
        check_eq("ovr_none", {31'd0, Ovr}, 32'd0);
        inB = 32'h22220002;
        vld = 4'b0010; tick();
        vld = 4'b0000;
        check_eq("ovr_pulse", {31'd0, Ovr}, 32'd1);
        tick();
        check_eq("ovr_single", {31'd0, Ovr}, 32'd0);
`ifdef FRAME_OVR_COUNT_EN
        check_eq("ovr_cnt", {16'd0, OvrCnt}, 32'd1);
`endif
        inA = 32'h33330001; inC = 32'h33330003; inD = 32'h33330004;
        vld = 4'b1101; tick();
        // A strobe on the launch edge belongs to the next frame
        inA = 32'h44440001;
        vld = 4'b0001; tick();
        vld = 4'b0000;
        check_eq("ovr_launch", {31'd0, nClkEn}, 32'd1);
        check_eq("ovr_B_second", B, 32'h22220002);
        check_eq("ovr_A_old", A, 32'h33330001);
        check_eq("ovr_Miss", {28'd0, Miss}, 32'd0);
        wait_not_busy("ovr_busy_end");

        // ---------------- carried-over flag completes the next frame
        inB = 32'h55550002; inC = 32'h55550003; inD = 32'h55550004;
        vld = 4'b1110; tick();
        vld = 4'b0000;
        tick();
        check_eq("carry_nClkEn", {31'd0, nClkEn}, 32'd1);
        check_eq("carry_A", A, 32'h44440001);
        check_eq("carry_Miss", {28'd0, Miss}, 32'd0);

        // ---------------- reset in the middle of BUSY
        repeat (10) tick();
        check_eq("mid_busy", {31'd0, Busy}, 32'd1);
        nReset = 1'b0;
        tick();
        check_eq("mrst_A", A, 32'd0);
        check_eq("mrst_B", B, 32'd0);
        check_eq("mrst_C", C, 32'd0);
        check_eq("mrst_D", D, 32'd0);
        check_eq("mrst_Miss", {28'd0, Miss}, 32'd0);
        check_eq("mrst_Busy", {31'd0, Busy}, 32'd0);
        check_eq("mrst_nClkEn", {31'd0, nClkEn}, 32'd0);
`ifdef FRAME_OVR_COUNT_EN
        check_eq("mrst_ovr_cnt", {16'd0, OvrCnt}, 32'd0);
`endif
        nReset = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (nClkEn || Busy) seen++;
        end
        check_eq("mrst_stays_idle", seen, 32'd0);
        inA = 32'h66660001; inB = 32'h66660002; inC = 32'h66660003; inD = 32'h66660004;
        vld = 4'b1111; tick();
        vld = 4'b0000;
        tick();
        check_eq("post_rst_nClkEn", {31'd0, nClkEn}, 32'd1);
        check_eq("post_rst_C", C, 32'h66660003);
        wait_not_busy("post_rst_busy_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter SER_CYCLES, default 35, giving serializer cycles per frame (sync byte plus 16 data bytes plus tail).
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving COLLECT cycles before a partial frame is forced.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port nReset, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port vld, input, 4 bits: per-channel sample strobe; bit0 is channel A, bit3 is channel D.
REQ-006 SHALL have ports inA, inB, inC, inD, input, 32 bits each: channel sample words.
REQ-007 SHALL have port nTXE, input, 1 bit: downstream FIFO full when 1.
REQ-008 SHALL have ports A, B, C, D, output, 32 bits each: frame words held for the serializer.
REQ-009 SHALL have port nClkEn, output, 1 bit: serializer start; high for one cycle restarts the byte sequence.
REQ-010 SHALL have port Busy, output, 1 bit: high in LAUNCH and BUSY.
REQ-011 SHALL have port Miss, output, 4 bits: channels absent from the last frame.
REQ-012 SHALL have port Ovr, output, 1 bit: one-cycle overrun pulse.

Function
REQ-013 SHALL keep four 32-bit capture registers and four flags; vld[i]=1 loads capture[i] and sets flag[i] on that edge.
REQ-014 SHALL pulse Ovr for one cycle when vld[i]=1 and flag[i] is already set; new data overwrites, other channels unaffected.
REQ-015 SHALL implement states IDLE (no flag set), COLLECT (at least one flag set), LAUNCH and BUSY.
REQ-016 IDLE SHALL go to COLLECT on any vld.
REQ-017 COLLECT SHALL go to LAUNCH when all four flags are set and nTXE=0.
REQ-018 COLLECT SHALL also go to LAUNCH when the timer reaches TIMEOUT and nTXE=0.
REQ-019 The timer SHALL count from 0 on COLLECT entry, saturate at TIMEOUT and hold while nTXE=1.
REQ-020 On the COLLECT-to-LAUNCH edge, SHALL load A..D from capture registers, load zero for channels with a clear flag, set Miss to the inverted flags and clear all flags.
REQ-021 A vld[i] on that same edge SHALL set flag[i] for the next frame; set wins over clear.
REQ-022 LAUNCH SHALL last exactly one cycle with nClkEn=1, then go to BUSY.
REQ-023 BUSY SHALL last exactly SER_CYCLES cycles, holding A..D stable, then go to COLLECT if any flag is set, else IDLE.
REQ-024 Launch latency SHALL be exactly one cycle from the edge that sets the last flag, when nTXE=0.
REQ-025 nTXE rising during BUSY SHALL NOT abort the frame; it is sampled only in COLLECT.
REQ-026 Capture SHALL continue during LAUNCH and BUSY (double buffering).

Reset
REQ-027 With nReset=0 at a rising edge: state IDLE, flags 0, timer 0, A..D 0, Miss 0, nClkEn 0, Busy 0, Ovr 0.
REQ-028 Reset mid-BUSY SHALL drop the frame; nClkEn stays 0, so the serializer finishes its current sequence and stays idle.

Configuration
REQ-029 With macro FRAME_OVR_COUNT_EN defined, SHALL add output OvrCnt, 16 bits: increments on each Ovr, saturates at 0xFFFF, clears on reset.
REQ-030 Without FRAME_OVR_COUNT_EN, OvrCnt and its logic SHALL be absent.

Structure
REQ-031 State encoding and the SER_CYCLES and TIMEOUT defaults SHALL live in shared package frame_pkg.
REQ-032 The per-channel capture register, flag and overrun detect SHALL be sub-module chan_capture, instantiated four times.

Verification
REQ-033 vld=0001..1000 on consecutive cycles, inA=0x11223344, nTXE=0 -> nClkEn=1 on the cycle after vld=1000; A=0x11223344; Busy high for 36 cycles; Miss=0000.
REQ-034 Only vld[0] and vld[2] pulse, nTXE=0 -> LAUNCH at timer=1023; B=0, D=0; Miss=1010.
REQ-035 All flags set while nTXE=1 for 100 cycles -> no nClkEn; nClkEn=1 one cycle after nTXE falls.
REQ-036 vld[1] twice before frame completes -> Ovr one pulse; B holds the second word; OvrCnt=1 when FRAME_OVR_COUNT_EN is defined.
REQ-037 nReset=0 at BUSY cycle 10 -> all outputs 0 next cycle; new frame launches normally after reset.
